// File: rtl/disp_pkg.sv
// Shared types for the debug display selector.
// Mode encoding and the mode-advance helper.
package disp_pkg;

    typedef enum logic [1:0] {
        MODE_PC  = 2'd0,
        MODE_RS  = 2'd1,
        MODE_RT  = 2'd2,
        MODE_ALU = 2'd3
    } mode_e;

    function automatic mode_e mode_step(input mode_e m);
        mode_e n;
        unique case (m)
            MODE_PC:  n = MODE_RS;
            MODE_RS:  n = MODE_RT;
            MODE_RT:  n = MODE_ALU;
            MODE_ALU: n = MODE_PC;
            default:  n = MODE_PC;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, debounce counter,
// and rising-edge press pulse on the accepted level.
module btn_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic clr_n,
    input  logic btn_in,
    output logic level,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          lvl_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            lvl_d <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            s1    <= btn_in;
            s2    <= s1;
            lvl_d <= level;
            // any return to the accepted level restarts the stability count
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign press = level & ~lvl_d;

endmodule

// File: rtl/disp_sel.sv
// Debug display selector: button-driven mode FSM and registered hex word.
// Freeze button logic is built only with DISP_SEL_HOLD_EN defined.
module disp_sel
    import disp_pkg::*;
#(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        btn_mode,
    input  logic        btn_hold,
    input  logic [31:0] pc,
    input  logic [31:0] next_pc,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] alu_result,
    input  logic [31:0] db_data,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [15:0] disp_data,
    output logic [1:0]  mode,
    output logic        held
);

    mode_e       mode_q;
    mode_e       mode_d;
    logic        mode_lvl;
    logic        mode_press;
    logic        held_q;
    logic [15:0] src;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode_btn (
        .clk    (clk),
        .clr_n  (clr_n),
        .btn_in (btn_mode),
        .level  (mode_lvl),
        .press  (mode_press)
    );

`ifdef DISP_SEL_HOLD_EN
    logic hold_lvl;
    logic hold_press;
    logic unused_bits;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_hold_btn (
        .clk    (clk),
        .clr_n  (clr_n),
        .btn_in (btn_hold),
        .level  (hold_lvl),
        .press  (hold_press)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            held_q <= 1'b0;
        end else if (hold_press) begin
            held_q <= ~held_q;
        end
    end

    assign unused_bits = &{1'b0, hold_lvl};
`else
    logic unused_bits;

    assign held_q      = 1'b0;
    assign unused_bits = &{1'b0, btn_hold};
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mode_q <= MODE_PC;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (mode_press) begin
            mode_d = mode_step(mode_q);
        end
    end

    always_comb begin
        src = 16'h0000;
        unique case (mode_q)
            MODE_PC:  src = {pc[7:0], next_pc[7:0]};
            MODE_RS:  src = {3'b000, rs_addr, rs_data[7:0]};
            MODE_RT:  src = {3'b000, rt_addr, rt_data[7:0]};
            MODE_ALU: src = {alu_result[7:0], db_data[7:0]};
            default:  src = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            disp_data <= 16'h0000;
        end else if (!held_q) begin
            disp_data <= src;
        end
    end

    logic unused_hi;
    assign unused_hi = &{1'b0, mode_lvl, unused_bits,
                         pc[31:8], next_pc[31:8],
                         rs_data[31:8], rt_data[31:8],
                         alu_result[31:8], db_data[31:8]};

    assign mode = mode_q;
    assign held = held_q;

endmodule

// File: doc/disp_sel.md
DISP_SEL -- requirements
Module: disp_sel

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1000000, meaning consecutive stable clk cycles required to accept a new button level.
REQ-002 SHALL have port clk  input  1  system clock; the only clock; all state on its rising edge.
REQ-003 SHALL have port clr_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port btn_mode  input  1  raw, asynchronous, bouncing mode-advance push-button.
REQ-005 SHALL have port btn_hold  input  1  raw, asynchronous, bouncing freeze toggle button.
REQ-006 SHALL have ports pc, next_pc, rs_data, rt_data, alu_result, db_data  input  32 each  CPU datapath values.
REQ-007 SHALL have ports rs_addr, rt_addr  input  5 each  register-file addresses.
REQ-008 SHALL have port disp_data  output  16  four hex digits for the 7-segment multiplexer downstream.
REQ-009 SHALL have port mode  output  2  current display mode.
REQ-010 SHALL have port held  output  1  high while disp_data is frozen.

Function
REQ-011 SHALL pass each button through a 2-flop synchronizer, then a debouncer: counter resets on any change of synchronized level vs. accepted level; accepted level updates when counter reaches DEB_CYCLES-1 with level still differing.
REQ-012 SHALL detect a rising edge of the accepted level as a one-cycle press pulse; release generates nothing.
REQ-013 SHALL implement mode FSM with states PC(0) -> RS(1) -> RT(2) -> ALU(3) -> PC(0); one step per btn_mode press pulse, registered the cycle after the pulse; wraps 3 -> 0.
REQ-014 SHALL form the source word: PC = {pc[7:0], next_pc[7:0]}; RS = {3'b000, rs_addr, rs_data[7:0]}; RT = {3'b000, rt_addr, rt_data[7:0]}; ALU = {alu_result[7:0], db_data[7:0]}.
REQ-015 SHALL register disp_data from the source word of the current mode each cycle; latency source-to-disp_data 1 cycle; after a mode change the new mode's word appears 1 cycle later.
REQ-016 SHALL toggle held on each btn_hold press pulse; while held=1 disp_data keeps its value regardless of sources or mode.
REQ-017 SHALL still advance mode while held=1; on release (held 1 -> 0) disp_data shows the current mode's word 1 cycle later.
REQ-018 SHALL, on simultaneous btn_mode and btn_hold pulses, apply both in the same cycle (mode advances, held toggles).
REQ-019 SHALL treat a glitch shorter than DEB_CYCLES cycles as no press; mode and held unchanged.

Reset
REQ-020 SHALL, on clr_n low, asynchronously force mode=0, held=0, disp_data=16'h0000, debouncer counters=0, accepted levels=0, synchronizers=0.
REQ-021 SHALL discard any press in progress when reset asserts mid-debounce; a button held through reset release is accepted as a press only after DEB_CYCLES stable cycles.
REQ-022 SHALL release reset cleanly; first disp_data update occurs on the first clk edge after clr_n high.

Configuration
REQ-023 SHALL compile the hold feature only when macro DISP_SEL_HOLD_EN is defined.
REQ-024 SHALL, without DISP_SEL_HOLD_EN, omit btn_hold's debouncer, tie held to 0, and ignore btn_hold; port list unchanged.

Structure
REQ-025 SHALL take the mode encoding type and constants MODE_PC, MODE_RS, MODE_RT, MODE_ALU from shared package disp_pkg.
REQ-026 SHALL implement synchronizer, debouncer and edge detect in sub-module btn_debounce (parameter DEB_CYCLES, ports clk, clr_n, btn_in, level, press), instantiated once per button.
REQ-027 SHALL size the debounce counter as $clog2(DEB_CYCLES) bits, minimum 1.

Verification (DEB_CYCLES=4)
REQ-028 SHALL cover reset: clr_n low mid-cycle with pc=32'h12 -> disp_data=0000, mode=0 immediately; after release disp_data=1214 with next_pc=32'h14.
REQ-029 SHALL cover mode cycling: four clean btn_mode presses -> mode 1,2,3,0; in mode 1 with rs_addr=5'h1F, rs_data=32'hAB -> disp_data=1FAB.
REQ-030 SHALL cover bounce: btn_mode toggled every 2 cycles for 10 cycles then low -> mode stays 0.
REQ-031 SHALL cover hold (DISP_SEL_HOLD_EN): press btn_hold with disp_data=1214, then change pc to 32'h99 and press btn_mode -> disp_data stays 1214, mode=1; press btn_hold again -> disp_data shows RS word 1 cycle after held falls.
REQ-032 SHALL cover simultaneous btn_mode and btn_hold presses -> mode increments and held toggles in the same cycle.
REQ-033 SHALL cover build without DISP_SEL_HOLD_EN: btn_hold pressed -> held=0, disp_data tracks sources.
